// File: rtl/udp_pkg.sv
// udp_pkg: shared constants, FSM state encoding and helpers for the UDP receiver.
// Header is four 16-bit big-endian words: src port, dst port, length, checksum.
package udp_pkg;

  localparam int unsigned UDP_HEAD_N = 8;   // UDP header size in bytes
  localparam int unsigned PORT_W     = 16;
  localparam int unsigned UDP_LEN_W  = 16;
  localparam int unsigned HDR_IDX_W  = 2;   // indexes header words 0..3

  localparam logic [HDR_IDX_W-1:0] W_SRC  = 2'd0;
  localparam logic [HDR_IDX_W-1:0] W_DST  = 2'd1;
  localparam logic [HDR_IDX_W-1:0] W_LEN  = 2'd2;
  localparam logic [HDR_IDX_W-1:0] W_CSUM = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEAD    = 2'd1,
    ST_DATA    = 2'd2,
    ST_DISCARD = 2'd3
  } rx_state_e;

  // Wire order puts the first (most significant) byte in the low lane.
  function automatic logic [15:0] be_word(input logic [15:0] beat);
    return {beat[7:0], beat[15:8]};
  endfunction

endpackage

// File: rtl/udp_port_match.sv
// udp_port_match: registered compare of one header word against a fixed port.
//   clk, reset  : clock, synchronous active-high reset
//   beat_i      : a header beat is being consumed this cycle
//   first_i     : this beat is header word 0 (restarts the compare)
//   idx_i       : header word index of this beat
//   word_i      : header word, already byte-swapped to host order
//   fail_o      : sticky mismatch flag for the current header
module udp_port_match
  import udp_pkg::*;
#(
  parameter logic [HDR_IDX_W-1:0] WORD_IDX = W_DST,
  parameter logic [PORT_W-1:0]    PORT     = 16'd0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 beat_i,
  input  logic                 first_i,
  input  logic [HDR_IDX_W-1:0] idx_i,
  input  logic [PORT_W-1:0]    word_i,
  output logic                 fail_o
);

  logic fail_q, fail_d, mismatch;

  assign mismatch = (idx_i == WORD_IDX) && (word_i != PORT);

  // Word 0 restarts the flag so a stale failure never leaks into a new header.
  always_comb begin
    fail_d = fail_q;
    if (beat_i) fail_d = first_i ? mismatch : (fail_q | mismatch);
  end

  always_ff @(posedge clk) begin
    if (reset) fail_q <= 1'b0;
    else       fail_q <= fail_d;
  end

  assign fail_o = fail_q;

endmodule

// File: rtl/udp_rx.sv
// udp_rx: strips the UDP header from an IPv4 payload stream, filters on ports,
// length and IPv4 checksum error, and forwards the payload to the application.
//   clk, reset                      : clock, synchronous active-high reset
//   valid_i/start_i/data_i/len_i    : IPv4 payload beat, first byte in data_i[7:0]
//   cancel_i, cs_err_i              : upstream abort, IPv4 header checksum error
//   valid_o/start_o/last_o/data_o/len_o : payload beat (combinational from input)
//   cancel_o                        : abort of a payload already started
//   drop_cnt_o                      : saturating count of discarded datagrams
module udp_rx
  import udp_pkg::*;
#(
  parameter int unsigned       DATA_W         = 16,
  parameter int unsigned       LEN_W          = $clog2(DATA_W/8+1),
  parameter bit                MATCH_SRC_PORT = 1'b0,
  parameter bit                MATCH_DST_PORT = 1'b1,
  parameter logic [PORT_W-1:0] SRC_PORT       = 16'd0,
  parameter logic [PORT_W-1:0] DST_PORT       = 16'd18000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic              start_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              cancel_i,
  input  logic              cs_err_i,
  output logic              valid_o,
  output logic              start_o,
  output logic              last_o,
  output logic [DATA_W-1:0] data_o,
  output logic [LEN_W-1:0]  len_o,
  output logic              cancel_o,
  output logic [15:0]       drop_cnt_o
);

  rx_state_e              state_q, state_d;
  logic [HDR_IDX_W-1:0]   hdr_cnt_q, hdr_cnt_d;
  logic [UDP_LEN_W-1:0]   rem_q, rem_d;
  logic [UDP_LEN_W-1:0]   ulen_q, ulen_d;
  logic                   err_q, err_d;
  logic                   first_q, first_d;
  logic [15:0]            drop_q, drop_d;

  logic                   is_start, hdr_beat, src_fail, dst_fail, hdr_fail;
  logic [HDR_IDX_W-1:0]   hdr_idx;
  logic [PORT_W-1:0]      hdr_word;
  logic [LEN_W-1:0]       take;

  assign is_start = valid_i & start_i;
  assign hdr_beat = is_start | (valid_i & (state_q == ST_HEAD));
  assign hdr_idx  = is_start ? W_SRC : hdr_cnt_q;
  assign hdr_word = be_word(data_i);
  // Bytes of this beat that still belong to the UDP payload.
  assign take     = (rem_q < UDP_LEN_W'(len_i)) ? LEN_W'(rem_q) : len_i;

  if (MATCH_SRC_PORT) begin : g_src
    udp_port_match #(.WORD_IDX(W_SRC), .PORT(SRC_PORT)) u_src (
      .clk(clk), .reset(reset), .beat_i(hdr_beat), .first_i(is_start),
      .idx_i(hdr_idx), .word_i(hdr_word), .fail_o(src_fail));
  end else begin : g_src_off
    assign src_fail = 1'b0;
  end

  if (MATCH_DST_PORT) begin : g_dst
    udp_port_match #(.WORD_IDX(W_DST), .PORT(DST_PORT)) u_dst (
      .clk(clk), .reset(reset), .beat_i(hdr_beat), .first_i(is_start),
      .idx_i(hdr_idx), .word_i(hdr_word), .fail_o(dst_fail));
  end else begin : g_dst_off
    assign dst_fail = 1'b0;
  end

  // Next state and payload outputs; cancel beats start beats, which beat a plain beat.
  always_comb begin
    state_d   = state_q;
    hdr_cnt_d = hdr_cnt_q;
    rem_d     = rem_q;
    ulen_d    = ulen_q;
    err_d     = err_q;
    first_d   = first_q;
    drop_d    = drop_q;
    hdr_fail  = 1'b0;
    valid_o   = 1'b0;
    start_o   = 1'b0;
    last_o    = 1'b0;
    cancel_o  = 1'b0;
    data_o    = data_i;
    len_o     = take;

    if (cancel_i) begin
      cancel_o = (state_q == ST_DATA);
      state_d  = ST_IDLE;
    end else if (is_start) begin
      // A start inside DATA means the previous datagram was truncated.
      cancel_o  = (state_q == ST_DATA);
      state_d   = ST_HEAD;
      hdr_cnt_d = 2'd1;
      err_d     = cs_err_i;
    end else if (valid_i) begin
      unique case (state_q)
        ST_HEAD: begin
          err_d     = err_q | cs_err_i;
          hdr_cnt_d = hdr_cnt_q + 2'd1;
          if (hdr_cnt_q == W_LEN) ulen_d = hdr_word;
          if (hdr_cnt_q == W_CSUM) begin
            hdr_fail = err_q | cs_err_i | src_fail | dst_fail |
                       (ulen_q < UDP_LEN_W'(UDP_HEAD_N));
            if (hdr_fail) begin
              state_d = ST_DISCARD;
              if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            end else if (ulen_q == UDP_LEN_W'(UDP_HEAD_N)) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DATA;
              rem_d   = ulen_q - UDP_LEN_W'(UDP_HEAD_N);
              first_d = 1'b1;
            end
          end
        end
        ST_DATA: begin
          valid_o = 1'b1;
          start_o = first_q;
          first_d = 1'b0;
          last_o  = (rem_q <= UDP_LEN_W'(len_i));
          rem_d   = rem_q - UDP_LEN_W'(take);
          if (last_o) state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hdr_cnt_q <= '0;
      rem_q     <= '0;
      ulen_q    <= '0;
      err_q     <= 1'b0;
      first_q   <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      hdr_cnt_q <= hdr_cnt_d;
      rem_q     <= rem_d;
      ulen_q    <= ulen_d;
      err_q     <= err_d;
      first_q   <= first_d;
      drop_q    <= drop_d;
    end
  end

  assign drop_cnt_o = drop_q;

endmodule
